// File: rtl/jk_counter_ctrl_pkg.sv
// Shared definitions for the JK-cell counter controller.
//   - State encoding constants and the FSM state type.
//   - Per-bit drive kinds and the helper that maps one to a {j,k} pair.
package jk_counter_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StRun  = ST_RUN,
        StDone = ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        DrvHold,
        DrvToggle,
        DrvSet,
        DrvClear
    } drive_e;

    // Returns {j, k} for a JK cell.
    function automatic logic [1:0] jk_drive(input drive_e op);
        logic [1:0] jk;
        jk = 2'b00;
        unique case (op)
            DrvHold:   jk = 2'b00;
            DrvToggle: jk = 2'b11;
            DrvSet:    jk = 2'b10;
            DrvClear:  jk = 2'b01;
            default:   jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_counter_ctrl_jk_cell.sv
// One JK flip-flop storage cell.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear
//   j, k  : JK inputs (00 hold, 01 clear, 10 set, 11 toggle)
//   q     : cell output
module jk_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= (j & ~q) | (~k & q);
        end
    end

endmodule

// File: rtl/jk_counter_ctrl.sv
// Sequences a bank of WIDTH JK cells as a modulo-MODULO up/down counter.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears cells and FSM)
//   en    : count enable
//   up    : direction, 1 = up, 0 = down
//   load  : synchronous parallel load (wins over counting)
//   d     : load value, clamped to MODULO-1
//   q     : counter value from the JK cell bank
//   tc    : terminal count, combinational, high in the cycle before a wrap
//   done  : high while stopped at terminal count (ONESHOT only)
module jk_counter_ctrl
    import jk_counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULO  = 10,
    parameter bit          ONESHOT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             done
);

    // MODULO may equal 2**WIDTH, so compare in WIDTH+1 bits.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULO - 1);

    state_e           state;
    logic             done_r;
    logic             count_en;
    logic             at_max;
    logic             at_zero;
    logic             out_of_range;
    logic [WIDTH-1:0] dl;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;

    assign count_en     = (state == StRun) && en;
    assign at_max       = (q == MAX_Q);
    assign at_zero      = (q == '0);
    assign out_of_range = ({1'b0, q} >= MOD_EXT);
    assign dl           = ({1'b0, d} < MOD_EXT) ? d : MAX_Q;

    assign tc   = count_en & ((up & at_max) | (~up & at_zero));
    assign done = done_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= StIdle;
            done_r <= 1'b0;
        end else if (load) begin
            state  <= StIdle;
            done_r <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (en) state <= StRun;
                end
                StRun: begin
                    if (!en) begin
                        state <= StIdle;
                    end else if (ONESHOT && tc) begin
                        state  <= StDone;
                        done_r <= 1'b1;
                    end
                end
                StDone: begin
                    state <= StDone;
                end
                default: begin
                    state  <= StIdle;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_bit
        // Mask of the bits below this one; empty for bit 0, so bit 0 always toggles.
        localparam logic [WIDTH-1:0] LOW = WIDTH'((32'd1 << g) - 32'd1);

        drive_e op;

        always_comb begin
            op = DrvHold;
            if (load) begin
                op = dl[g] ? DrvSet : DrvClear;
            end else if (count_en) begin
                if (up) begin
                    // Wrap and out-of-range recovery both clear to zero.
                    if (at_max || out_of_range) begin
                        op = q[g] ? DrvClear : DrvHold;
                    end else if ((q & LOW) == LOW) begin
                        op = DrvToggle;
                    end
                end else begin
                    if (at_zero) begin
                        op = MAX_Q[g] ? DrvSet : DrvClear;
                    end else if ((q & LOW) == '0) begin
                        op = DrvToggle;
                    end
                end
            end
        end

        assign {j[g], k[g]} = jk_drive(op);

        jk_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (j[g]),
            .k     (k[g]),
            .q     (q[g])
        );
    end

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Bench for jk_counter_ctrl: a free-running instance and a one-shot instance
// share all inputs and are both compared against a behavioural model.
module tb_jk_counter_ctrl;

    localparam int MOD = 10;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] d = '0;
    logic [3:0] q0, q1;
    logic       tc0, tc1, done0, done1;

    int checks = 0;
    int failures = 0;

    // Model: counter value and mode per instance (0 free-running, 1 one-shot).
    int mq[2];
    int ms[2];

    always #5 clk = ~clk;

    jk_counter_ctrl #(.WIDTH(4), .MODULO(MOD), .ONESHOT(1'b0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .up    (up),
        .load  (load),
        .d     (d),
        .q     (q0),
        .tc    (tc0),
        .done  (done0)
    );

    jk_counter_ctrl #(.WIDTH(4), .MODULO(MOD), .ONESHOT(1'b1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .up    (up),
        .load  (load),
        .d     (d),
        .q     (q1),
        .tc    (tc1),
        .done  (done1)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_tc(input int i);
        if (ms[i] != M_RUN || !en) return 0;
        if (up) return (mq[i] == MOD - 1) ? 1 : 0;
        return (mq[i] == 0) ? 1 : 0;
    endfunction

    function automatic void model_step(input int i, input bit oneshot);
        bit term;
        if (load) begin
            mq[i] = (int'(d) < MOD) ? int'(d) : MOD - 1;
            ms[i] = M_IDLE;
            return;
        end
        case (ms[i])
            M_IDLE: if (en) ms[i] = M_RUN;
            M_RUN: begin
                if (!en) begin
                    ms[i] = M_IDLE;
                end else begin
                    term = (model_tc(i) != 0);
                    if (up) mq[i] = (mq[i] >= MOD - 1) ? 0 : mq[i] + 1;
                    else    mq[i] = (mq[i] == 0) ? MOD - 1 : mq[i] - 1;
                    if (oneshot && term) ms[i] = M_DONE;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i] = 0;
            ms[i] = M_IDLE;
        end
    endfunction

    // One clock: tc before the edge, q/done after it, both instances.
    task automatic tick();
        @(negedge clk);
        check("tc0", int'(tc0), model_tc(0));
        check("tc1", int'(tc1), model_tc(1));
        @(posedge clk);
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        #1;
        check("q0", int'(q0), mq[0]);
        check("q1", int'(q1), mq[1]);
        check("done0", int'(done0), (ms[0] == M_DONE) ? 1 : 0);
        check("done1", int'(done1), (ms[1] == M_DONE) ? 1 : 0);
    endtask

    // Assert reset between edges and confirm outputs clear without a clock.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_q0", int'(q0), 0);
        check("rst_q1", int'(q1), 0);
        check("rst_done1", int'(done1), 0);
        check("rst_tc0", int'(tc0), 0);
        check("rst_tc1", int'(tc1), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_in(input bit e, input bit u, input bit l, input int dv);
        en = e;
        up = u;
        load = l;
        d = 4'(dv);
    endtask

    typedef struct {
        bit en;
        bit up;
        bit load;
        int d;
        int q;
        bit tc;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // Expected q after the edge and tc before it, free-running instance.
        tbl[0]  = '{en: 0, up: 0, load: 1, d: 7,  q: 7, tc: 0};
        tbl[1]  = '{en: 0, up: 0, load: 1, d: 12, q: 9, tc: 0};
        tbl[2]  = '{en: 1, up: 1, load: 0, d: 0,  q: 9, tc: 0};
        tbl[3]  = '{en: 1, up: 1, load: 0, d: 0,  q: 0, tc: 1};
        tbl[4]  = '{en: 1, up: 1, load: 0, d: 0,  q: 1, tc: 0};
        tbl[5]  = '{en: 1, up: 1, load: 1, d: 5,  q: 5, tc: 0};
        tbl[6]  = '{en: 1, up: 0, load: 0, d: 0,  q: 5, tc: 0};
        tbl[7]  = '{en: 1, up: 0, load: 0, d: 0,  q: 4, tc: 0};
        tbl[8]  = '{en: 0, up: 0, load: 0, d: 0,  q: 4, tc: 0};
        tbl[9]  = '{en: 0, up: 0, load: 1, d: 0,  q: 0, tc: 0};
        tbl[10] = '{en: 1, up: 0, load: 0, d: 0,  q: 0, tc: 0};
        tbl[11] = '{en: 1, up: 0, load: 0, d: 0,  q: 9, tc: 1};
        tbl[12] = '{en: 1, up: 1, load: 0, d: 0,  q: 0, tc: 1};

        model_reset();
        #3;
        check("init_q0", int'(q0), 0);
        check("init_done0", int'(done0), 0);
        check("init_tc0", int'(tc0), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle after release.
        for (int i = 0; i < 3; i++) tick();
        check("idle_q0", int'(q0), 0);

        // Table vectors.
        for (int i = 0; i < 13; i++) begin
            set_in(tbl[i].en, tbl[i].up, tbl[i].load, tbl[i].d);
            @(negedge clk);
            check($sformatf("vec%0d_tc", i), int'(tc0), int'(tbl[i].tc));
            @(posedge clk);
            model_step(0, 1'b0);
            model_step(1, 1'b1);
            #1;
            check($sformatf("vec%0d_q", i), int'(q0), tbl[i].q);
            check($sformatf("vec%0d_mq1", i), int'(q1), mq[1]);
            check($sformatf("vec%0d_md1", i), int'(done1), (ms[1] == M_DONE) ? 1 : 0);
        end

        // One-shot: up from 8 stops at 0 with done.
        set_in(0, 1, 1, 8);
        tick();
        set_in(1, 1, 0, 0);
        tick();
        check("os_entry_q1", int'(q1), 8);
        tick();
        check("os_q1_9", int'(q1), 9);
        tick();
        check("os_wrap_q1", int'(q1), 0);
        check("os_done1", int'(done1), 1);
        check("os_free_q0", int'(q0), 0);
        check("os_free_done0", int'(done0), 0);
        tick();
        tick();
        check("os_hold_q1", int'(q1), 0);
        check("os_hold_tc1", int'(tc1), 0);
        set_in(1, 1, 1, 3);
        tick();
        check("os_load_q1", int'(q1), 3);
        check("os_load_done1", int'(done1), 0);

        // Direction flip then asynchronous reset mid-run.
        set_in(1, 1, 0, 0);
        tick();
        tick();
        tick();
        check("flip_q0_5", int'(q0), 5);
        up = 1'b0;
        tick();
        check("flip_q0_4", int'(q0), 4);
        do_reset();
        tick();
        check("post_rst_q0", int'(q0), 0);

        // Randomised run against the model.
        for (int n = 0; n < 600; n++) begin
            set_in(($urandom_range(0, 9) < 8), $urandom_range(0, 1) == 1,
                   ($urandom_range(0, 19) == 0), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
